// File: rtl/abr_params_pkg.sv
// Shared memory-port definitions used by blocks attached to the polynomial memory.
package abr_params_pkg;

  localparam int ABR_MEM_ADDR_WIDTH = 15;

  // Read/write command carried with every memory request.
  typedef enum logic [1:0] {
    RW_IDLE  = 2'b00,
    RW_READ  = 2'b01,
    RW_WRITE = 2'b10
  } mem_rw_mode_e;

  // One memory port request: command plus word address.
  typedef struct packed {
    mem_rw_mode_e                  rd_wr_en;
    logic [ABR_MEM_ADDR_WIDTH-1:0] addr;
  } mem_if_t;

endpackage

// File: rtl/pkencode_pkg.sv
// Constants and FSM encoding for the t1 public-key packer.
package pkencode_pkg;

  localparam int MLDSA_K           = 8;
  localparam int MLDSA_N           = 256;
  localparam int REG_SIZE          = 24;
  localparam int OUTPUT_COEFF_SIZE = 10;
  localparam int API_ADDR_WIDTH    = 16;

  // Eight coefficients are consumed per request pair.
  localparam int LANES = 8;
  localparam int LAST  = MLDSA_K * MLDSA_N / LANES;

  // Memory stores t1 scaled by 2^SHIFT.
  localparam int SHIFT = 13;

  // Counter width must hold LAST itself (DRAIN compares against it).
  localparam int CNT_W = $clog2(LAST + 1);

  localparam int PACK_W = LANES * OUTPUT_COEFF_SIZE;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } pk_state_e;

endpackage

// File: rtl/pkencode_if.sv
// Two 4-lane read ports onto the shared polynomial memory.
interface pkencode_if;
  import abr_params_pkg::*;
  import pkencode_pkg::*;

  mem_if_t                      mem_a_rd_req;
  mem_if_t                      mem_b_rd_req;
  logic [3:0][REG_SIZE-1:0]     mem_a_rd_data;
  logic [3:0][REG_SIZE-1:0]     mem_b_rd_data;

  // Requester side (the packer).
  modport master (
    output mem_a_rd_req,
    output mem_b_rd_req,
    input  mem_a_rd_data,
    input  mem_b_rd_data
  );

  // Memory side.
  modport slave (
    input  mem_a_rd_req,
    input  mem_b_rd_req,
    output mem_a_rd_data,
    output mem_b_rd_data
  );

endinterface

// File: rtl/pkencode_lane_pack.sv
// Combinational lane packer: strips the 2^13 scaling from eight coefficients,
// concatenates the 10-bit t1 fields and flags any coefficient that is not a
// well-formed scaled t1 value.
module pkencode_lane_pack
  import pkencode_pkg::*;
(
  input  logic [LANES-1:0][REG_SIZE-1:0] coeffs,
  output logic [PACK_W-1:0]              packed_word,
  output logic                           fmt_err
);

  logic [LANES-1:0] lane_err;

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      // Field gi of the packed word is bits [22:13] of lane gi.
      assign packed_word[gi*OUTPUT_COEFF_SIZE +: OUTPUT_COEFF_SIZE] =
        coeffs[gi][SHIFT +: OUTPUT_COEFF_SIZE];
      // Bit 23 or any fractional bit set means the word is not t1 * 2^13.
      assign lane_err[gi] = coeffs[gi][REG_SIZE-1] | (|coeffs[gi][SHIFT-1:0]);
    end
  endgenerate

  assign fmt_err = |lane_err;

endmodule

// File: rtl/pkencode.sv
// t1 public-key packer: streams LAST request pairs to memory and writes one
// 80-bit packed word per returned pair to the API buffer.
module pkencode
  import abr_params_pkg::*;
  import pkencode_pkg::*;
(
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          zeroize,
  input  logic                          pkencode_enable,
  input  logic [ABR_MEM_ADDR_WIDTH-1:0] src_base_addr,
  pkencode_if.master                    mem,
  output logic                          API_wr_en,
  output logic [API_ADDR_WIDTH-1:0]     API_wr_address,
  output logic [PACK_W-1:0]             API_wr_data,
  output logic                          pkencode_done,
  output logic                          pkencode_err
);

  pk_state_e                     state;
  pk_state_e                     state_next;
  logic                          start;
  logic                          issue;

  logic [ABR_MEM_ADDR_WIDTH-1:0] locked_src_addr;
  logic [CNT_W-1:0]              rd_cnt;
  logic [CNT_W-1:0]              wr_cnt;
  logic                          req_vld;
  logic                          rdata_vld;
  mem_if_t                       req_a;
  mem_if_t                       req_b;
  logic [ABR_MEM_ADDR_WIDTH-1:0] addr_a;
  logic [ABR_MEM_ADDR_WIDTH-1:0] addr_b;

  logic [LANES-1:0][REG_SIZE-1:0] coeffs;
  logic [PACK_W-1:0]              packed_word;
  logic                           fmt_err;

  // Group i lives at two consecutive words; wrap is modular in the address width.
  assign addr_a = locked_src_addr + ABR_MEM_ADDR_WIDTH'({rd_cnt, 1'b0});
  assign addr_b = addr_a + ABR_MEM_ADDR_WIDTH'(1);

  assign mem.mem_a_rd_req = req_a;
  assign mem.mem_b_rd_req = req_b;

  // Lanes 0-3 come from port A, lanes 4-7 from port B.
  assign coeffs = {mem.mem_b_rd_data, mem.mem_a_rd_data};

  pkencode_lane_pack u_lane_pack (
    .coeffs      (coeffs),
    .packed_word (packed_word),
    .fmt_err     (fmt_err)
  );

  assign pkencode_done = (state == ST_DONE);

  // FSM state register; zeroize behaves like reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else if (zeroize) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic and the start/issue strobes that steer the datapath.
  always_comb begin
    state_next = state;
    start      = 1'b0;
    issue      = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (pkencode_enable) begin
          start      = 1'b1;
          state_next = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        issue = 1'b1;
        if (rd_cnt == CNT_W'(LAST - 1)) begin
          state_next = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (wr_cnt == CNT_W'(LAST)) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Request stage: base latch, read counter and registered port requests.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      locked_src_addr <= '0;
      rd_cnt          <= '0;
      req_vld         <= 1'b0;
      req_a           <= '{rd_wr_en: RW_IDLE, addr: '0};
      req_b           <= '{rd_wr_en: RW_IDLE, addr: '0};
    end else if (zeroize) begin
      locked_src_addr <= '0;
      rd_cnt          <= '0;
      req_vld         <= 1'b0;
      req_a           <= '{rd_wr_en: RW_IDLE, addr: '0};
      req_b           <= '{rd_wr_en: RW_IDLE, addr: '0};
    end else begin
      if (start) begin
        locked_src_addr <= src_base_addr;
        rd_cnt          <= '0;
      end
      if (issue) begin
        req_a   <= '{rd_wr_en: RW_READ, addr: addr_a};
        req_b   <= '{rd_wr_en: RW_READ, addr: addr_b};
        req_vld <= 1'b1;
        rd_cnt  <= rd_cnt + CNT_W'(1);
      end else begin
        req_a   <= '{rd_wr_en: RW_IDLE, addr: '0};
        req_b   <= '{rd_wr_en: RW_IDLE, addr: '0};
        req_vld <= 1'b0;
      end
    end
  end

  // Valid tracks the one-cycle memory read latency.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdata_vld <= 1'b0;
    end else if (zeroize) begin
      rdata_vld <= 1'b0;
    end else begin
      rdata_vld <= req_vld;
    end
  end

  // API stage: register the packed word; data/address hold between writes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      API_wr_en      <= 1'b0;
      API_wr_address <= '0;
      API_wr_data    <= '0;
      wr_cnt         <= '0;
    end else if (zeroize) begin
      API_wr_en      <= 1'b0;
      API_wr_address <= '0;
      API_wr_data    <= '0;
      wr_cnt         <= '0;
    end else begin
      API_wr_en <= rdata_vld;
      if (start) begin
        wr_cnt <= '0;
      end
      if (rdata_vld) begin
        API_wr_data    <= packed_word;
        API_wr_address <= API_ADDR_WIDTH'(wr_cnt);
        wr_cnt         <= wr_cnt + CNT_W'(1);
      end
    end
  end

  // Sticky format error, cleared only by a new start.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pkencode_err <= 1'b0;
    end else if (zeroize) begin
      pkencode_err <= 1'b0;
    end else if (start) begin
      pkencode_err <= 1'b0;
    end else if (rdata_vld && fmt_err) begin
      pkencode_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pkencode.sv
// Self-checking bench for pkencode: memory model, per-run reference of the
// expected packed words, and cycle-exact checks of requests, writes and done.
module tb_pkencode;
  import abr_params_pkg::*;
  import pkencode_pkg::*;

  localparam int AW    = ABR_MEM_ADDR_WIDTH;
  localparam int DEPTH = 1 << AW;

  logic              clk;
  logic              reset_n;
  logic              zeroize;
  logic              pkencode_enable;
  logic [AW-1:0]     src_base_addr;
  logic              API_wr_en;
  logic [API_ADDR_WIDTH-1:0] API_wr_address;
  logic [PACK_W-1:0] API_wr_data;
  logic              pkencode_done;
  logic              pkencode_err;

  pkencode_if mem_bus ();

  pkencode dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .zeroize         (zeroize),
    .pkencode_enable (pkencode_enable),
    .src_base_addr   (src_base_addr),
    .mem             (mem_bus),
    .API_wr_en       (API_wr_en),
    .API_wr_address  (API_wr_address),
    .API_wr_data     (API_wr_data),
    .pkencode_done   (pkencode_done),
    .pkencode_err    (pkencode_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory contents: each word holds four 24-bit lanes.
  logic [3:0][23:0] mem_arr [DEPTH];

  // Memory model: registered read, data valid one cycle after the request.
  always @(posedge clk) begin
    if (mem_bus.mem_a_rd_req.rd_wr_en == RW_READ)
      mem_bus.mem_a_rd_data <= mem_arr[mem_bus.mem_a_rd_req.addr];
    if (mem_bus.mem_b_rd_req.rd_wr_en == RW_READ)
      mem_bus.mem_b_rd_data <= mem_arr[mem_bus.mem_b_rd_req.addr];
  end

  int n_cmp = 0;
  int n_mis = 0;

  logic [PACK_W-1:0] exp_word [LAST];
  bit                exp_err  [LAST];

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, ".req_a"}, 128'(mem_bus.mem_a_rd_req), 128'(0));
    chk({tag, ".req_b"}, 128'(mem_bus.mem_b_rd_req), 128'(0));
    chk({tag, ".wr_en"}, 128'(API_wr_en), 128'(0));
    chk({tag, ".wr_addr"}, 128'(API_wr_address), 128'(0));
    chk({tag, ".wr_data"}, 128'(API_wr_data), 128'(0));
    chk({tag, ".done"}, 128'(pkencode_done), 128'(0));
    chk({tag, ".err"}, 128'(pkencode_err), 128'(0));
  endtask

  function automatic int word_idx(input int base, input int g, input int j);
    return (base + 2 * g + j / 4) % DEPTH;
  endfunction

  // mode 0: all 7FE000; 1: ramp (g+j)%1024; 2: random valid; 3: random, ~1/16 malformed
  task automatic fill(input int base, input int mode);
    for (int g = 0; g < LAST; g++) begin
      for (int j = 0; j < LANES; j++) begin
        logic [23:0] v;
        case (mode)
          0: v = 24'h7FE000;
          1: v = 24'(((g + j) % 1024) * 8192);
          2: v = 24'($urandom_range(0, 1023) * 8192);
          default: v = ($urandom_range(0, 15) == 0) ? 24'($urandom())
                                                   : 24'($urandom_range(0, 1023) * 8192);
        endcase
        mem_arr[word_idx(base, g, j)][j % 4] = v;
      end
    end
  endtask

  // Reference: each field is floor(c / 2^13) mod 1024; malformed if c >= 2^23 or c mod 2^13 != 0.
  task automatic build_model(input int base);
    for (int g = 0; g < LAST; g++) begin
      logic [PACK_W-1:0] w;
      bit e;
      w = '0;
      e = 1'b0;
      for (int j = 0; j < LANES; j++) begin
        int c;
        c = int'(mem_arr[word_idx(base, g, j)][j % 4]);
        w = w | (PACK_W'((c / 8192) % 1024) << (OUTPUT_COEFF_SIZE * j));
        if (c >= 32'h800000 || (c % 8192) != 0) e = 1'b1;
      end
      exp_word[g] = w;
      exp_err[g]  = e;
    end
  endtask

  // One run; caller is at a negedge. abort_kind: 0 none, 1 zeroize, 2 reset_n.
  task automatic run_pk(input string name, input int base, input int abort_kind,
                        input int abort_at, input int rep1, input int rep2, input int tail);
    bit aborted;
    int writes;
    int dones;
    int fails0;
    fails0  = n_mis;
    aborted = 1'b0;
    writes  = 0;
    dones   = 0;
    build_model(base);
    src_base_addr   = AW'(base);
    pkencode_enable = 1'b1;
    for (int n = 1; n <= LAST + 4 + tail; n++) begin
      @(negedge clk);
      pkencode_enable = 1'b0;
      if (!reset_n) reset_n = 1'b1;
      if (zeroize) begin
        chk_reset_outputs({name, ".zeroize"});
        zeroize = 1'b0;
      end
      if (API_wr_en) writes++;
      if (pkencode_done) dones++;
      if (aborted) begin
        chk({name, ".abort_wr_en"}, 128'(API_wr_en), 128'(0));
        chk({name, ".abort_done"}, 128'(pkencode_done), 128'(0));
      end else begin
        mem_if_t ea, eb;
        bit      err_exp;
        ea = '0;
        eb = '0;
        if (n >= 2 && n <= LAST + 1) begin
          ea.rd_wr_en = RW_READ;
          ea.addr     = AW'((base + 2 * (n - 2)) % DEPTH);
          eb.rd_wr_en = RW_READ;
          eb.addr     = AW'((base + 2 * (n - 2) + 1) % DEPTH);
        end
        chk({name, ".req_a"}, 128'(mem_bus.mem_a_rd_req), 128'(ea));
        chk({name, ".req_b"}, 128'(mem_bus.mem_b_rd_req), 128'(eb));
        chk({name, ".wr_en"}, 128'(API_wr_en), 128'(n >= 4 && n <= LAST + 3));
        if (n >= 4 && n <= LAST + 3) begin
          chk({name, ".wr_addr"}, 128'(API_wr_address), 128'(n - 4));
          chk({name, ".wr_data"}, 128'(API_wr_data), 128'(exp_word[n - 4]));
        end else if (n > LAST + 3) begin
          chk({name, ".hold_addr"}, 128'(API_wr_address), 128'(LAST - 1));
          chk({name, ".hold_data"}, 128'(API_wr_data), 128'(exp_word[LAST - 1]));
        end
        chk({name, ".done"}, 128'(pkencode_done), 128'(n == LAST + 4));
        err_exp = 1'b0;
        for (int g = 0; g <= n - 4 && g < LAST; g++) err_exp |= exp_err[g];
        chk({name, ".err"}, 128'(pkencode_err), 128'(err_exp));
      end
      if (n == rep1 || n == rep2) pkencode_enable = 1'b1;
      if (abort_kind == 1 && n == abort_at) begin
        zeroize = 1'b1;
        aborted = 1'b1;
      end
      if (abort_kind == 2 && n == abort_at) begin
        reset_n = 1'b0;
        #1;
        chk_reset_outputs({name, ".reset_n"});
        aborted = 1'b1;
      end
    end
    $display("run %-14s base=%04h writes=%0d done_pulses=%0d err=%0b new_mismatches=%0d",
             name, base, writes, dones, pkencode_err, n_mis - fails0);
  endtask

  initial begin
    int b;
    reset_n         = 1'b0;
    zeroize         = 1'b0;
    pkencode_enable = 1'b0;
    src_base_addr   = '0;
    repeat (2) @(negedge clk);
    chk_reset_outputs("por");
    reset_n = 1'b1;
    @(negedge clk);

    fill(0, 0);
    run_pk("all_7fe000", 0, 0, -1, -1, -1, 4);

    fill(32'h40, 1);
    run_pk("ramp", 32'h40, 0, -1, -1, -1, 4);

    fill(0, 2);
    mem_arr[word_idx(0, 17, 5)][1] = 24'h800001;
    run_pk("err_g17", 0, 0, -1, -1, -1, 4);
    fill(0, 2);
    run_pk("err_cleared", 0, 0, -1, -1, -1, 4);

    fill(0, 2);
    run_pk("zeroize", 0, 1, 100, -1, -1, 4);
    run_pk("after_zeroize", 0, 0, -1, -1, -1, 4);

    run_pk("reenable", 0, 0, -1, 50, 258, 4);

    run_pk("rst_mid", 0, 2, 120, -1, -1, 4);
    run_pk("after_rst", 0, 0, -1, -1, -1, 4);

    b = $urandom_range(0, DEPTH - 1);
    fill(b, 3);
    run_pk("rand_a", b, 0, -1, -1, -1, 1);
    b = $urandom_range(0, DEPTH - 1);
    fill(b, 3);
    run_pk("rand_b2b", b, 0, -1, -1, -1, 4);
    b = DEPTH - 100;
    fill(b, 3);
    run_pk("rand_wrap", b, 0, -1, -1, -1, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
